unaligned_mem_port: RTL
=======================

Name: unaligned_mem_port

Overview:
- Byte-addressed load/store front end for a word-organised synchronous RAM (1-cycle read latency, per-byte write enables).
- Supports byte/half/word(/dword) accesses at any byte offset, including accesses that straddle two RAM words.
- Aligned accesses use one RAM beat; straddling accesses use two.
- Sits between the CPU datapath (load/store unit) and the data memory macro.

Parameters:
- DATA_W, 32, RAM word and CPU data width in bits; power of two, >=16.
- ADDR_W, 32, CPU byte-address width.
- MEM_AW, 10, RAM word-address width; word index wraps modulo 2^MEM_AW.
- (derived) BYTES = DATA_W/8; OFF_W = log2(BYTES).

Ports:
- clka  in  1  clock, all logic posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword; nbytes = min(1<<size, BYTES).
- req_signed  in  1  sign-extend load result (ignored for stores and full-width loads).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, LSB-aligned.
- rsp_valid  out  1  one-cycle completion pulse (load data or store ack).
- rsp_rdata  out  DATA_W  load result, LSB-aligned and extended; 0 for stores.
- rsp_err  out  1  access error (see Optional Feature).
- mem_addr  out  MEM_AW  RAM word address.
- mem_we  out  1  RAM write strobe.
- mem_be  out  BYTES  RAM byte enables.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after the address.

Behaviour:
- Reset (async, immediate): state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; mem_we=0; mem_be=0; mem_addr=0; mem_wdata=0.
- Reset mid-operation aborts the access; pending second beat is never issued.
- Address decode at accept:
  - w = req_addr[ADDR_W-1:OFF_W] truncated to MEM_AW; o = req_addr[OFF_W-1:0].
  - cross = (o + nbytes > BYTES).
  - Second beat address = w+1 mod 2^MEM_AW (top word wraps to word 0).
- FSM states: IDLE, BEAT1, CAP0, CAP1, RESP. Request fields are registered at accept (cycle T).
- Loads:
  - T: mem_addr = w; mem_we = 0.
  - Non-cross: CAP0 at T+1 latches lo = mem_rdata; RESP at T+2 (rsp_valid=1).
  - Cross: BEAT1 at T+1 drives mem_addr = w+1 and latches lo; CAP1 at T+2 latches hi; RESP at T+3.
  - Result = ({hi,lo} >> 8*o) masked to nbytes, then zero- or sign-extended.
- Stores:
  - T: mem_we = 1, mem_addr = w, mem_be = (mask << o) truncated to BYTES, mem_wdata = req_wdata << 8*o.
  - Cross: BEAT1 at T+1 writes w+1 with be = mask >> (BYTES-o) and wdata = req_wdata >> 8*(BYTES-o).
  - RESP at T+1 (non-cross) or T+2 (cross).
  - No read-modify-write; unused byte lanes are untouched.
- RESP lasts one cycle; FSM then returns to IDLE. rsp_rdata holds its value until the next RESP.
- req_valid while req_ready=0 is ignored; the requester must hold it.
- mem_we is high only in the T and BEAT1 store cycles; mem_be=0 whenever mem_we=0.

Optional Feature:
- Macro: UNALIGNED_MEM_PORT_TRAP_EN.
- Defined: a crossing access performs no RAM beat (mem_we stays 0). FSM goes IDLE -> RESP, with rsp_valid=1, rsp_err=1 and rsp_rdata=0 at T+1.
- Non-crossing accesses behave as without the macro.
- Not defined: rsp_err is tied 0 and crossing accesses are split into two beats as above.

Decomposition:
- Package mem_acc_pkg: size encodings (SZ_B/SZ_H/SZ_W/SZ_D), FSM state enum, and a function computing the nbytes mask.
- Sub-module byte_lane_align (combinational):
  - Store path: lo/hi wdata and byte-enable generation.
  - Load path: shift, mask and sign/zero extension.
- The FSM and registers stay in unaligned_mem_port.

Test Plan (DATA_W=32, MEM_AW=10, RAM word0=0x44332211, word1=0x88776655):
- Word load at addr 0x4 -> a single read of mem_addr 1; rsp_rdata=0x88776655 with rsp_valid at T+2.
- Word load at addr 0x2 -> mem_addr 0 at T, then 1 at T+1; rsp_rdata=0x66554433 at T+3.
- Byte load at addr 0x7: signed -> 0xFFFFFF88; unsigned -> 0x00000088. Half load at addr 0x3, signed -> 0x00005544.
- Word store of 0xAABBCCDD at addr 0x3:
  - Beat 0: addr 0, be=4'b1000, wdata=0xDD000000.
  - Beat 1: addr 1, be=4'b0111, wdata=0x00AABBCC.
  - Readback: word0=0xDD332211, word1=0x88AABBCC.
- Word load at addr 0xFFE -> beats at mem_addr 1023 then 0 (wrap).
- rst_n low at T+1 of a crossing store -> mem_we=0 immediately, no second beat, req_ready=1 after release.
- With UNALIGNED_MEM_PORT_TRAP_EN, load at addr 0x2 -> rsp_err=1 at T+1 and no RAM access.

Source files
------------

// File: rtl/mem_acc_pkg.sv
// Shared definitions for the unaligned memory port.
// Contents: access-size encodings, the FSM state enum, and a helper that
// turns an access size into a byte mask (saturated later to the RAM width).
// Optional feature macro used by the design: UNALIGNED_MEM_PORT_TRAP_EN.
package mem_acc_pkg;

  // Widest access the size encoding can express (dword).
  localparam int MAX_BYTES = 8;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEAT1 = 3'd1,
    ST_CAP0  = 3'd2,
    ST_CAP1  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Low-order ones mask covering 1<<size bytes. Truncating it to the RAM
  // width yields min(1<<size, BYTES) ones, which is the clamped access size.
  function automatic logic [MAX_BYTES-1:0] size_mask(input logic [1:0] size);
    logic [MAX_BYTES-1:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      SZ_D:    m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/unaligned_mem_port_if.sv
// Bus bundle for the unaligned memory port: CPU request/response channel and
// the RAM-side word interface.
//   req_*  : load/store request from the CPU (valid/ready handshake)
//   rsp_*  : one-cycle completion pulse with load data and error flag
//   mem_*  : word address, write strobe, byte enables and data to the RAM
// Modports: slave = the port logic, master = the CPU plus RAM surroundings.
// Optional feature macro used by the design: UNALIGNED_MEM_PORT_TRAP_EN.
interface unaligned_mem_port_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 10
) ();
  localparam int BYTES = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_we;
  logic [BYTES-1:0]  mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_we, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_we, mem_be, mem_wdata
  );
endinterface

// File: rtl/unaligned_mem_port_byte_lane_align.sv
// Combinational byte-lane steering for unaligned accesses.
// Store path: st_size_i/st_off_i/st_wdata_i -> first-word (lo) and
//   second-word (hi) byte enables and write data, plus cross_o when the
//   access spills into the next RAM word.
// Load path: ld_lo_i/ld_hi_i (two consecutive RAM words) shifted right by
//   ld_off_i bytes, masked to the access size, zero/sign extended -> ld_data_o.
// Optional feature macro used by the design: UNALIGNED_MEM_PORT_TRAP_EN.
module byte_lane_align
  import mem_acc_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int BYTES  = DATA_W / 8,
  localparam int OFF_W  = $clog2(BYTES)
) (
  input  logic [1:0]        st_size_i,
  input  logic [OFF_W-1:0]  st_off_i,
  input  logic [DATA_W-1:0] st_wdata_i,
  output logic [BYTES-1:0]  st_be_lo_o,
  output logic [BYTES-1:0]  st_be_hi_o,
  output logic [DATA_W-1:0] st_wd_lo_o,
  output logic [DATA_W-1:0] st_wd_hi_o,
  output logic              cross_o,
  input  logic [1:0]        ld_size_i,
  input  logic [OFF_W-1:0]  ld_off_i,
  input  logic              ld_signed_i,
  input  logic [DATA_W-1:0] ld_lo_i,
  input  logic [DATA_W-1:0] ld_hi_i,
  output logic [DATA_W-1:0] ld_data_o
);
  logic [BYTES-1:0]    st_mask_s;
  logic [BYTES-1:0]    ld_mask_s;
  logic [2*BYTES-1:0]  st_be_ext_s;
  logic [2*DATA_W-1:0] st_wd_ext_s;
  logic [DATA_W-1:0]   ld_shift_s;
  logic                ld_sign_s;

  assign st_mask_s = BYTES'(size_mask(st_size_i));
  assign ld_mask_s = BYTES'(size_mask(ld_size_i));

  // Store lanes: shift mask/data across a two-word window; the upper half is
  // what lands in the following RAM word, so any bit there means a crossing.
  always_comb begin
    st_be_ext_s = {{BYTES{1'b0}}, st_mask_s} << st_off_i;
    st_wd_ext_s = {{DATA_W{1'b0}}, st_wdata_i} << {st_off_i, 3'b000};
  end

  assign st_be_lo_o = st_be_ext_s[BYTES-1:0];
  assign st_be_hi_o = st_be_ext_s[2*BYTES-1:BYTES];
  assign st_wd_lo_o = st_wd_ext_s[DATA_W-1:0];
  assign st_wd_hi_o = st_wd_ext_s[2*DATA_W-1:DATA_W];
  assign cross_o    = |st_be_ext_s[2*BYTES-1:BYTES];

  // Load lanes: the sign comes from the top byte inside the mask; lanes
  // outside the mask are filled with it (full-width loads have no such lanes).
  always_comb begin
    ld_shift_s = DATA_W'({ld_hi_i, ld_lo_i} >> {ld_off_i, 3'b000});
    ld_sign_s  = 1'b0;
    for (int i = 0; i < BYTES; i++) begin
      ld_sign_s = ld_mask_s[i] ? (ld_signed_i & ld_shift_s[8*i+7]) : ld_sign_s;
    end
    for (int i = 0; i < BYTES; i++) begin
      ld_data_o[8*i +: 8] = ld_mask_s[i] ? ld_shift_s[8*i +: 8] : {8{ld_sign_s}};
    end
  end

endmodule

// File: rtl/unaligned_mem_port.sv
// Byte-addressed load/store front end for a word-organised synchronous RAM
// (1-cycle read latency, per-byte write enables). Accesses that straddle two
// RAM words are split into two beats; aligned ones use a single beat.
// Ports: clka (posedge clock), rst_n (async active-low reset),
//   bus_io (slave modport: CPU request/response + RAM word interface).
// Optional feature macro: UNALIGNED_MEM_PORT_TRAP_EN -- when defined, a
//   crossing access does not touch the RAM and completes with rsp_err=1.
module unaligned_mem_port
  import mem_acc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 10
) (
  input logic                 clka,
  input logic                 rst_n,
  unaligned_mem_port_if.slave bus_io
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  state_e            state_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [MEM_AW-1:0] addr_q;
  logic              we1_q;
  logic [BYTES-1:0]  be1_q;
  logic [DATA_W-1:0] wd1_q;
  logic [DATA_W-1:0] lo_q;
  logic [OFF_W-1:0]  off_q;
  logic [1:0]        size_q;
  logic              signed_q;

  logic [MEM_AW-1:0] w_s;
  logic [OFF_W-1:0]  off_s;
  logic              accept_s;
  logic              cross_s;
  logic              trap_s;
  logic              unused_addr_s;
  logic [BYTES-1:0]  st_be_lo_s;
  logic [BYTES-1:0]  st_be_hi_s;
  logic [DATA_W-1:0] st_wd_lo_s;
  logic [DATA_W-1:0] st_wd_hi_s;
  logic [DATA_W-1:0] ld_lo_s;
  logic [DATA_W-1:0] ld_hi_s;
  logic [DATA_W-1:0] ld_data_s;
  logic [MEM_AW-1:0] mem_addr_s;
  logic              mem_we_s;
  logic [BYTES-1:0]  mem_be_s;
  logic [DATA_W-1:0] mem_wdata_s;

  // Word index wraps modulo 2^MEM_AW; address bits above it are ignored.
  assign w_s           = bus_io.req_addr[OFF_W +: MEM_AW];
  assign off_s         = bus_io.req_addr[OFF_W-1:0];
  assign unused_addr_s = ^bus_io.req_addr;
  assign accept_s      = bus_io.req_valid && (state_q == ST_IDLE);

`ifdef UNALIGNED_MEM_PORT_TRAP_EN
  assign trap_s = cross_s;
`else
  assign trap_s = 1'b0;
`endif

  byte_lane_align #(.DATA_W(DATA_W)) u_align (
    .st_size_i   (bus_io.req_size),
    .st_off_i    (off_s),
    .st_wdata_i  (bus_io.req_wdata),
    .st_be_lo_o  (st_be_lo_s),
    .st_be_hi_o  (st_be_hi_s),
    .st_wd_lo_o  (st_wd_lo_s),
    .st_wd_hi_o  (st_wd_hi_s),
    .cross_o     (cross_s),
    .ld_size_i   (size_q),
    .ld_off_i    (off_q),
    .ld_signed_i (signed_q),
    .ld_lo_i     (ld_lo_s),
    .ld_hi_i     (ld_hi_s),
    .ld_data_o   (ld_data_s)
  );

  // Load window: CAP1 pairs the saved first word with the second word now on
  // mem_rdata; CAP0 only needs the single word currently returned.
  always_comb begin
    if (state_q == ST_CAP1) begin
      ld_lo_s = lo_q;
      ld_hi_s = bus_io.mem_rdata;
    end else begin
      ld_lo_s = bus_io.mem_rdata;
      ld_hi_s = '0;
    end
  end

  // RAM drive: the first beat must reach the RAM in the accept cycle, so it
  // is steered straight from the request; the second beat comes from flops.
  always_comb begin
    mem_addr_s  = addr_q;
    mem_we_s    = we1_q;
    mem_be_s    = be1_q;
    mem_wdata_s = wd1_q;
    if (state_q == ST_IDLE && bus_io.req_valid) begin
      mem_addr_s = w_s;
      if (bus_io.req_we && !trap_s) begin
        mem_we_s    = 1'b1;
        mem_be_s    = st_be_lo_s;
        mem_wdata_s = st_wd_lo_s;
      end else begin
        mem_we_s    = 1'b0;
        mem_be_s    = '0;
        mem_wdata_s = '0;
      end
    end else begin
      mem_addr_s = addr_q;
    end
  end

  assign bus_io.mem_addr  = mem_addr_s;
  assign bus_io.mem_we    = mem_we_s;
  assign bus_io.mem_be    = mem_be_s;
  assign bus_io.mem_wdata = mem_wdata_s;
  assign bus_io.req_ready = (state_q == ST_IDLE);
  assign bus_io.rsp_valid = rsp_valid_q;
  assign bus_io.rsp_rdata = rsp_rdata_q;
  assign bus_io.rsp_err   = rsp_err_q;

  // Access sequencer: accept, optional second beat, capture, one-cycle response.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      addr_q      <= '0;
      we1_q       <= 1'b0;
      be1_q       <= '0;
      wd1_q       <= '0;
      lo_q        <= '0;
      off_q       <= '0;
      size_q      <= 2'd0;
      signed_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          if (accept_s) begin
            off_q    <= off_s;
            size_q   <= bus_io.req_size;
            signed_q <= bus_io.req_signed;
            addr_q   <= w_s + MEM_AW'(1);
            if (trap_s) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (bus_io.req_we && cross_s) begin
              state_q <= ST_BEAT1;
              we1_q   <= 1'b1;
              be1_q   <= st_be_hi_s;
              wd1_q   <= st_wd_hi_s;
            end else if (bus_io.req_we) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q <= cross_s ? ST_BEAT1 : ST_CAP0;
            end
          end
        end
        ST_BEAT1: begin
          if (we1_q) begin
            // Second store beat is on the bus this cycle; drop it afterwards.
            we1_q       <= 1'b0;
            be1_q       <= '0;
            wd1_q       <= '0;
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            lo_q    <= bus_io.mem_rdata;
            state_q <= ST_CAP1;
          end
        end
        ST_CAP0, ST_CAP1: begin
          rsp_rdata_q <= ld_data_s;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
